// File: rtl/overdrive_pkg.sv
// Shared types and constants for the overdrive pipeline.
// Mode encoding is visible to software, so keep it stable.
package overdrive_pkg;

    typedef enum logic [1:0] {
        OD_BYPASS,
        OD_HARD,
        OD_SOFT,
        OD_ASYM
    } od_mode_t;

    // Slope above the soft knee is 1/2^KNEE_SH.
    localparam int KNEE_SH = 2;

endpackage

// File: rtl/od_shaper.sv
// Combinational clip shaper and output saturation.
// Takes the gained sample p and the dry sample; produces y and a clip flag.
module od_shaper
    import overdrive_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 6
) (
    input  od_mode_t                        mode,
    input  logic signed [DATA_W+GAIN_W:0]   p,
    input  logic signed [DATA_W-1:0]        dry,
    output logic signed [DATA_W-1:0]        y,
    output logic                            clip
);

    localparam int PW = DATA_W + GAIN_W + 1;
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (DATA_W-1)) - 1);
    localparam logic signed [PW-1:0] MINV = -PW'(1 << (DATA_W-1));
    localparam logic signed [PW-1:0] TV   = PW'(1 << (DATA_W-2));

    logic signed [PW-1:0] k;
    logic signed [PW-1:0] lo;

    always_comb begin
        k    = p;
        lo   = MINV;
        y    = dry;
        clip = 1'b0;
        unique case (mode)
            OD_BYPASS, OD_HARD: ;
            OD_SOFT: begin
                if (p > TV)
                    k = TV + ((p - TV) >>> KNEE_SH);
                else if (p < -TV)
                    k = -TV + ((p + TV) >>> KNEE_SH);
            end
            OD_ASYM: lo = -TV;
        endcase
        // The knee only bends the curve; only the final clamp counts as clipping.
        if (mode != OD_BYPASS) begin
            if (k > MAXV) begin
                y    = MAXV[DATA_W-1:0];
                clip = 1'b1;
            end else if (k < lo) begin
                y    = lo[DATA_W-1:0];
                clip = 1'b1;
            end else begin
                y    = k[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/overdrive_pipe.sv
// Three-stage gain + clip-shaper pipeline with valid/ready streaming
// and a saturating clip counter.
module overdrive_pipe
    import overdrive_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 6,
    parameter int FRAC_W = 2,
    parameter int CH_W   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic signed [DATA_W-1:0] IN_DATA,
    input  logic [CH_W-1:0]          IN_CH,
    input  logic [GAIN_W-1:0]        GAIN,
    input  od_mode_t                 MODE,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic signed [DATA_W-1:0] OUT_DATA,
    output logic [CH_W-1:0]          OUT_CH,
    output logic                     CLIP_OUT,
    output logic [CNT_W-1:0]         CLIP_CNT,
    input  logic                     CNT_CLR
);

    localparam int PW = DATA_W + GAIN_W + 1;

    logic en;

    logic                     v1;
    logic signed [DATA_W-1:0] d1;
    logic [CH_W-1:0]          c1;
    logic [GAIN_W-1:0]        g1;
    od_mode_t                 m1;

    logic                     v2;
    logic signed [PW-1:0]     p2;
    logic signed [DATA_W-1:0] dry2;
    logic [CH_W-1:0]          c2;
    od_mode_t                 m2;

    logic signed [PW-1:0]     d1x;
    logic signed [PW-1:0]     g1x;
    logic signed [PW-1:0]     prod;
    logic signed [DATA_W-1:0] y3;
    logic                     clip3;

    // Single global stall: every stage moves only when the output can drain.
    assign en       = !OUT_VALID || OUT_READY;
    assign IN_READY = en;

    assign d1x  = {{(PW-DATA_W){d1[DATA_W-1]}}, d1};
    assign g1x  = {{(PW-GAIN_W){1'b0}}, g1};
    assign prod = d1x * g1x;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            v1 <= 1'b0;
            d1 <= '0;
            c1 <= '0;
            g1 <= '0;
            m1 <= OD_BYPASS;
        end else if (en) begin
            v1 <= IN_VALID;
            d1 <= IN_DATA;
            c1 <= IN_CH;
            g1 <= GAIN;
            m1 <= MODE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            v2   <= 1'b0;
            p2   <= '0;
            dry2 <= '0;
            c2   <= '0;
            m2   <= OD_BYPASS;
        end else if (en) begin
            v2   <= v1;
            p2   <= prod >>> FRAC_W;
            dry2 <= d1;
            c2   <= c1;
            m2   <= m1;
        end
    end

    od_shaper #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_shaper (
        .mode (m2),
        .p    (p2),
        .dry  (dry2),
        .y    (y3),
        .clip (clip3)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
            CLIP_OUT  <= 1'b0;
        end else if (en) begin
            OUT_VALID <= v2;
            OUT_DATA  <= y3;
            OUT_CH    <= c2;
            CLIP_OUT  <= clip3;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            CLIP_CNT <= '0;
        else if (CNT_CLR)
            CLIP_CNT <= '0;
        else if (OUT_VALID && OUT_READY && CLIP_OUT && CLIP_CNT != '1)
            CLIP_CNT <= CLIP_CNT + CNT_W'(1);
    end

endmodule

// File: tb/tb_overdrive_pipe.sv
// Scoreboard bench for overdrive_pipe: directed corners plus random
// traffic against an arithmetic reference model.
module tb_overdrive_pipe;
    import overdrive_pkg::*;

    logic        CLK, RESET_N, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic        CLIP_OUT, CNT_CLR;
    logic [0:0]  IN_CH, OUT_CH;
    logic [15:0] IN_DATA, OUT_DATA, CLIP_CNT;
    logic [5:0]  GAIN;
    od_mode_t    MODE;

    typedef struct {
        logic [15:0] y;
        logic        ch;
        logic        clip;
        int          iss;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_stall = -1;
    int   mcnt = 0;
    bit   rdy_rand = 0;

    overdrive_pipe dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .IN_CH     (IN_CH),
        .GAIN      (GAIN),
        .MODE      (MODE),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_CH    (OUT_CH),
        .CLIP_OUT  (CLIP_OUT),
        .CLIP_CNT  (CLIP_CNT),
        .CNT_CLR   (CNT_CLR)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (rdy_rand) OUT_READY = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Gain is GAIN/4 with floor; knee at 2^14, output range is 16-bit signed.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [5:0] g,
                                          input od_mode_t m);
        int p, k, lo, t;
        t  = 16384;
        lo = -32768;
        p  = (int'($signed(x)) * int'(g)) >>> 2;
        k  = p;
        if (m == OD_BYPASS) return {1'b0, x};
        if (m == OD_SOFT) begin
            if (p > t) k = t + ((p - t) >>> 2);
            else if (p < -t) k = -t + ((p + t) >>> 2);
        end
        if (m == OD_ASYM) lo = -t;
        if (k > 32767) return {1'b1, 16'h7FFF};
        if (k < lo) return {1'b1, 16'(lo)};
        return {1'b0, 16'(k)};
    endfunction

    task automatic issue(input logic [15:0] x, input logic ch, input logic [5:0] g,
                         input od_mode_t m, input logic [16:0] e);
        bit done;
        exp_t it;
        done = 0;
        IN_VALID = 1;
        IN_DATA  = x;
        IN_CH    = ch;
        GAIN     = g;
        MODE     = m;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge CLK);
            if (IN_READY && RESET_N) begin
                it.y    = e[15:0];
                it.ch   = ch;
                it.clip = e[16];
                it.iss  = cyc;
                exp_q.push_back(it);
                done = 1;
            end
            @(posedge CLK);
            #1;
        end
        IN_VALID = 0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL handshake_timeout: got no IN_READY required within 500 cycles");
        end
    endtask

    task automatic send(input logic [15:0] x, input logic ch, input logic [5:0] g,
                        input od_mode_t m);
        issue(x, ch, g, m, model(x, g, m));
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                exp_q.delete();
                mcnt = 0;
                chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
                chk("rst_clip_cnt", 32'(CLIP_CNT), 32'd0);
            end else begin
                chk("clip_cnt", 32'(CLIP_CNT), 32'(mcnt));
                if (OUT_VALID && !OUT_READY) begin
                    last_stall = cyc;
                    chk("in_ready_stalled", 32'(IN_READY), 32'd0);
                end
                if (OUT_READY) chk("in_ready_free", 32'(IN_READY), 32'd1);
                if (OUT_VALID && OUT_READY) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_output: got data %h required no output", OUT_DATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 32'(OUT_DATA), 32'(e.y));
                        chk("out_ch", 32'(OUT_CH), 32'(e.ch));
                        chk("clip_out", 32'(CLIP_OUT), 32'(e.clip));
                        if (last_stall < e.iss) chk("latency", 32'(cyc - e.iss), 32'd3);
                        if (CNT_CLR) mcnt = 0;
                        else if (e.clip && mcnt < 65535) mcnt++;
                    end
                end else if (CNT_CLR) begin
                    mcnt = 0;
                end
            end
        end
    end

    initial begin
        RESET_N   = 0;
        IN_VALID  = 0;
        IN_DATA   = 0;
        IN_CH     = 0;
        GAIN      = 0;
        MODE      = OD_BYPASS;
        OUT_READY = 1;
        CNT_CLR   = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
        chk("reset_out_data", 32'(OUT_DATA), 32'd0);
        chk("reset_out_ch", 32'(OUT_CH), 32'd0);
        chk("reset_clip_out", 32'(CLIP_OUT), 32'd0);
        chk("reset_clip_cnt", 32'(CLIP_CNT), 32'd0);
        RESET_N = 1;
        @(posedge CLK);
        #1;

        issue(16'h3000, 1'b0, 6'd8, OD_HARD, {1'b0, 16'h6000});
        issue(16'h5000, 1'b0, 6'd8, OD_HARD, {1'b1, 16'h7FFF});
        issue(16'hB000, 1'b1, 6'd8, OD_HARD, {1'b1, 16'h8000});
        drain();
        chk("clip_cnt_two", 32'(CLIP_CNT), 32'd2);

        issue(16'h3000, 1'b0, 6'd4,  OD_SOFT,   {1'b0, 16'h3000});
        issue(16'h3000, 1'b1, 6'd8,  OD_SOFT,   {1'b0, 16'h4800});
        issue(16'h7FFF, 1'b0, 6'd63, OD_SOFT,   {1'b1, 16'h7FFF});
        issue(16'hF000, 1'b1, 6'd8,  OD_ASYM,   {1'b0, 16'hE000});
        issue(16'hC000, 1'b0, 6'd8,  OD_ASYM,   {1'b1, 16'hC000});
        issue(16'h5000, 1'b0, 6'd8,  OD_ASYM,   {1'b1, 16'h7FFF});
        issue(16'h7ABC, 1'b1, 6'd63, OD_BYPASS, {1'b0, 16'h7ABC});
        issue(16'h7FFF, 1'b0, 6'd0,  OD_HARD,   {1'b0, 16'h0000});
        issue(16'h8000, 1'b1, 6'd0,  OD_SOFT,   {1'b0, 16'h0000});
        drain();

        fork
            for (int i = 0; i < 6; i++)
                send(16'($urandom), 1'($urandom), 6'($urandom),
                     od_mode_t'($urandom_range(0, 3)));
            begin
                repeat (3) @(posedge CLK);
                #1;
                OUT_READY = 0;
                repeat (5) begin
                    @(negedge CLK);
                    chk("stall_window_in_ready", 32'(IN_READY), 32'd0);
                end
                @(posedge CLK);
                #1;
                OUT_READY = 1;
            end
        join
        drain();

        CNT_CLR = 1;
        send(16'h5000, 1'b0, 6'd8, OD_HARD);
        drain();
        chk("cnt_clr_wins", 32'(CLIP_CNT), 32'd0);
        CNT_CLR = 0;
        send(16'hB000, 1'b0, 6'd8, OD_HARD);
        drain();
        chk("cnt_after_clr", 32'(CLIP_CNT), 32'd1);

        rdy_rand = 1;
        for (int i = 0; i < 1500; i++)
            send(16'($urandom), 1'($urandom), 6'($urandom),
                 od_mode_t'($urandom_range(0, 3)));
        rdy_rand = 0;
        @(posedge CLK);
        #2;
        OUT_READY = 1;
        drain();

        send(16'h5000, 1'b0, 6'd8, OD_HARD);
        send(16'hB000, 1'b1, 6'd8, OD_HARD);
        send(16'h1234, 1'b0, 6'd8, OD_SOFT);
        RESET_N = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_clip_cnt", 32'(CLIP_CNT), 32'd0);
        RESET_N = 1;
        repeat (8) @(posedge CLK);
        #1;
        chk("postrst_clip_cnt", 32'(CLIP_CNT), 32'd0);
        send(16'h0100, 1'b1, 6'd12, OD_HARD);
        drain();

        for (int i = 0; i < 65540; i++)
            send(16'h5000, 1'($urandom), 6'd8, OD_HARD);
        drain();
        chk("clip_cnt_saturated", 32'(CLIP_CNT), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
